// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file geometry, address windows and requester ids
package regfile_pkg;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int I2C_REG  = 6;
  localparam int PWM_BASE = 8;
  typedef enum logic [1:0] {REQ_CPU, REQ_I2C, REQ_ENV} req_e;
endpackage

// File: rtl/starve_counter.sv
// starve_counter: saturating wait counter; clk, rst(async low), i_inc, i_clr -> o_starved at LIMIT
module starve_counter #(
  parameter int LIMIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_starved
);
  localparam int CW = $clog2(LIMIT + 1);
  logic [CW-1:0] r_cnt;
  assign o_starved = r_cnt == CW'(LIMIT);
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_inc && !o_starved) r_cnt <= r_cnt + 1'b1;
endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: cpu/i2c/env arbitration onto one registered regfile write port; ports cpu_*/i2c_*/env_* handshakes, write_en/wrData/DataIn, err_flag/err_clr
module reg_write_arbiter
  import regfile_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_valid,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic              cpu_ready,
  input  logic              i2c_valid,
  input  logic [ADDR_W-1:0] i2c_addr,
  input  logic [DATA_W-1:0] i2c_data,
  output logic              i2c_ready,
  input  logic              env_valid,
  input  logic [ADDR_W-1:0] env_addr,
  input  logic [DATA_W-1:0] env_data,
  output logic              env_ready,
  output logic              write_en,
  output logic [ADDR_W-1:0] wrData,
  output logic [DATA_W-1:0] DataIn,
  output logic              err_flag,
  input  logic              err_clr
);
  req_e              w_sel, w_rr_sel;
  logic              w_any, w_st_i, w_st_e, w_i2c_starved, w_env_starved, w_viol, w_ok;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              r_rr;
  starve_counter #(.LIMIT(STARVE_LIMIT)) u_i2c_cnt (
    .clk(clk), .rst(rst), .i_inc(i2c_valid & ~i2c_ready), .i_clr(~i2c_valid | i2c_ready),
    .o_starved(w_i2c_starved));
  starve_counter #(.LIMIT(STARVE_LIMIT)) u_env_cnt (
    .clk(clk), .rst(rst), .i_inc(env_valid & ~env_ready), .i_clr(~env_valid | env_ready),
    .o_starved(w_env_starved));
  // a saturated counter only pre-empts while its requester is still asking
  assign w_st_i   = i2c_valid & w_i2c_starved;
  assign w_st_e   = env_valid & w_env_starved;
  assign w_rr_sel = r_rr ? REQ_ENV : REQ_I2C;
  assign w_sel    = (w_st_i & w_st_e)         ? w_rr_sel :
                    w_st_i                    ? REQ_I2C  :
                    w_st_e                    ? REQ_ENV  :
                    cpu_valid                 ? REQ_CPU  :
                    (i2c_valid & env_valid)   ? w_rr_sel :
                    i2c_valid                 ? REQ_I2C  : REQ_ENV;
  assign w_any     = rst & (cpu_valid | i2c_valid | env_valid);
  assign cpu_ready = w_any & (w_sel == REQ_CPU);
  assign i2c_ready = w_any & (w_sel == REQ_I2C);
  assign env_ready = w_any & (w_sel == REQ_ENV);
  assign w_addr = (w_sel == REQ_CPU) ? cpu_addr : (w_sel == REQ_I2C) ? i2c_addr : env_addr;
  assign w_data = (w_sel == REQ_CPU) ? cpu_data : (w_sel == REQ_I2C) ? i2c_data : env_data;
  // writes to reg0 are silently dropped and never count as window violations
  assign w_viol = (w_addr != '0) &
                  ((i2c_ready & (w_addr != ADDR_W'(I2C_REG))) | (env_ready & (w_addr < ADDR_W'(PWM_BASE))));
  assign w_ok   = w_any & (w_addr != '0) & ~w_viol;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      write_en <= 1'b0;
      wrData   <= '0;
      DataIn   <= '0;
      err_flag <= 1'b0;
      r_rr     <= 1'b0;
    end else begin
      write_en <= w_ok;
      if (w_any) begin
        wrData <= w_addr;
        DataIn <= w_data;
      end
      if (w_viol) err_flag <= 1'b1;
      else if (err_clr) err_flag <= 1'b0;
      if (i2c_ready | env_ready) r_rr <= ~r_rr;
    end
endmodule
